// File: rtl/scan_frame_capture.sv
// Captures an 8x8 column-scanned frame from a one-hot column strobe and exposes it for random reads.
// Optional FRAME_DOUBLE_BUFFER_EN: separate capture/visible buffers with atomic commit.
module scan_frame_capture (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] turn,
    input  logic [7:0] display,
    input  logic [2:0] read_addr,
    output logic [7:0] read_data,
    output logic       frame_done,
    output logic       frame_valid,
    output logic [7:0] frame_count,
    output logic       scan_error,
    output logic       error_seen
);

    localparam int unsigned NCOL = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned DW   = 8;

    typedef enum logic {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [DW-1:0]   visible [NCOL];

    logic [DW-1:0]   expect_c;
    logic            wr_en_c;
    logic [CW-1:0]   wr_col_c;
    logic            commit_c;
    logic            err_c;
    logic            restart_c;

    // Classify the current strobe against the expected column.
    always_comb begin
        expect_c  = DW'(8'h01 << col);
        wr_en_c   = 1'b0;
        wr_col_c  = col;
        commit_c  = 1'b0;
        err_c     = 1'b0;
        restart_c = 1'b0;
        case (state)
            SYNC: begin
                if (turn == 8'h01) begin
                    wr_en_c  = 1'b1;
                    wr_col_c = '0;
                end
            end
            CAPTURE: begin
                if (turn == 8'h00) begin
                    wr_en_c = 1'b0;
                end else if (turn == expect_c) begin
                    wr_en_c  = 1'b1;
                    commit_c = (col == CW'(NCOL - 1));
                end else begin
                    err_c = 1'b1;
                    if (turn == 8'h01) begin
                        restart_c = 1'b1;
                        wr_en_c   = 1'b1;
                        wr_col_c  = '0;
                    end
                end
            end
            default: begin
                wr_en_c = 1'b0;
            end
        endcase
    end

    // Scan-order state machine and status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= SYNC;
            col         <= '0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            scan_error  <= 1'b0;
            error_seen  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            scan_error <= 1'b0;
            case (state)
                SYNC: begin
                    if (wr_en_c) begin
                        col   <= CW'(1);
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (err_c) begin
                        scan_error <= 1'b1;
                        error_seen <= 1'b1;
                        if (restart_c) begin
                            col <= CW'(1);
                        end else begin
                            col   <= '0;
                            state <= SYNC;
                        end
                    end else if (wr_en_c) begin
                        col <= CW'(col + CW'(1));
                        if (commit_c) begin
                            frame_done  <= 1'b1;
                            frame_valid <= 1'b1;
                            frame_count <= DW'(frame_count + DW'(1));
                        end
                    end
                end
                default: begin
                    state <= SYNC;
                    col   <= '0;
                end
            endcase
        end
    end

`ifdef FRAME_DOUBLE_BUFFER_EN
    logic [DW-1:0] capture [NCOL];

    // Columns land in the capture buffer; the visible frame swaps in whole at commit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NCOL; i++) begin
                capture[i] <= '0;
                visible[i] <= '0;
            end
            read_data <= '0;
        end else begin
            read_data <= visible[read_addr];
            if (wr_en_c) begin
                capture[wr_col_c] <= display;
            end
            if (commit_c) begin
                for (int i = 0; i < NCOL - 1; i++) begin
                    visible[i] <= capture[i];
                end
                visible[NCOL-1] <= display;
            end
        end
    end
`else
    // Single buffer: every accepted column is immediately visible.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NCOL; i++) begin
                visible[i] <= '0;
            end
            read_data <= '0;
        end else begin
            read_data <= visible[read_addr];
            if (wr_en_c) begin
                visible[wr_col_c] <= display;
            end
        end
    end
`endif

endmodule

// File: doc/scan_frame_capture.md
SCAN_FRAME_CAPTURE -- requirements
Module: scan_frame_capture

Interface
REQ-001 The block SHALL have these ports, one per line:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- turn  input  8  one-hot column strobe from the snake display driver; turn[i]=1 selects column i; 8'h00 means blank/idle cycle.
- display  input  8  row data for the column selected by turn in the same cycle.
- read_addr  input  3  column index to read from the visible frame.
- read_data  output  8  registered row data of column read_addr.
- frame_done  output  1  one-cycle pulse when a complete frame is committed.
- frame_valid  output  1  high once at least one complete frame has been committed since reset.
- frame_count  output  8  number of committed frames, modulo 256.
- scan_error  output  1  one-cycle pulse on a scan-order violation.
- error_seen  output  1  sticky flag, set by any scan_error, cleared only by reset.
REQ-002 Parameters: none; width fixed at 8x8.

Function
REQ-003 State machine SHALL have two states: SYNC (waiting for scan start) and CAPTURE (collecting columns); expected-column counter col[2:0].
REQ-004 In SYNC: turn==8'h01 SHALL store display into capture column 0, set col=1, and enter CAPTURE; any other turn value, including 8'h00, SHALL be ignored without error.
REQ-005 In CAPTURE: turn==8'h00 SHALL be an idle cycle; col and capture buffer unchanged; no error.
REQ-006 In CAPTURE: turn==(8'h01<<col) SHALL store display into capture column col and increment col; col wraps 7->0.
REQ-007 In CAPTURE: storing column 7 SHALL commit the frame: frame_done=1 in the following cycle, frame_count+1 (255 wraps to 0), frame_valid=1, state stays CAPTURE expecting column 0.
REQ-008 In CAPTURE: any other turn value (wrong column, multiple bits set) SHALL pulse scan_error for one cycle in the following cycle, set error_seen, discard the partial frame, and enter SYNC with col=0.
REQ-009 Error exception: if the offending value is exactly 8'h01, it SHALL be treated as a fresh start instead: store column 0, col=1, stay CAPTURE, still pulse scan_error.
REQ-010 read_data SHALL equal visible-frame column read_addr, one cycle latency.
REQ-011 Commit and read in the same edge: read_data SHALL return the frame visible before that edge; the new frame is visible from the next read.
REQ-012 frame_done and scan_error SHALL never both be 1 in the same cycle.

Reset
REQ-013 With reset==0 at a rising edge, the block SHALL enter SYNC with col=0, clear all capture and visible columns to 8'h00, and drive read_data=0, frame_done=0, frame_valid=0, frame_count=0, scan_error=0, error_seen=0.
REQ-014 Reset mid-frame SHALL discard partial data with no frame_done or scan_error pulse; reset has priority over all other inputs.

Configuration
REQ-015 Macro FRAME_DOUBLE_BUFFER_EN defined: separate capture and visible buffers; visible buffer loads all 8 columns atomically at commit; partial or errored frames are never visible.
REQ-016 Macro FRAME_DOUBLE_BUFFER_EN undefined: single buffer; each accepted column writes directly to the visible frame; partial frames are visible; frame_done, frame_count, frame_valid and error behaviour are unchanged.

Verification
REQ-017 Reset held for 2 cycles, then turn=8'h00 for 10 cycles -> all outputs 0; state SYNC.
REQ-018 Scan turn=01,02,...,80 with display=8'hA0+i -> frame_done pulses one cycle after turn=80; frame_count=1; frame_valid=1; read_addr=3 returns 8'hA3 next cycle.
REQ-019 Two back-to-back frames with 8'h00 idle cycles inserted between columns 2 and 3 -> no scan_error; frame_count=2; contents correct.
REQ-020 After columns 0-2, drive turn=8'h10 -> scan_error pulse; error_seen=1; frame_count unchanged. With FRAME_DOUBLE_BUFFER_EN, read_addr=1 returns the previous frame's data; without it, returns the new column 1 data.
REQ-021 Drive 256 valid frames -> frame_count wraps to 8'h00; frame_valid stays 1.
REQ-022 Reset asserted after column 5 of a frame -> no frame_done; all outputs 0 the following cycle; a following full scan commits with frame_count=1.
